boot_loader: RTL and testbench

BOOT_LOADER -- requirements
Module: boot_loader

---
 rtl/common_params.sv | 20 ++
 rtl/boot_loader_if.sv | 28 ++
 rtl/boot_word_asm.sv | 43 ++++
 rtl/boot_loader.sv | 144 ++++++++++++++
 tb/tb_boot_loader.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/common_params.sv
// Shared widths and the boot FSM state encoding for the boot loader.
// CHK is present only when BOOT_CHECKSUM_EN is defined.
package common_params;

  localparam int BITS  = 32;
  localparam int ADDRW = 13;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
`ifdef BOOT_CHECKSUM_EN
    CHK    = 3'd4,
`endif
    DONE   = 3'd5,
    ERROR  = 3'd6
  } boot_state_t;

endpackage

// File: rtl/boot_loader_if.sv
// Boot loader bus: UART byte stream in, I-MEM write port and status out.
interface boot_loader_if;
  import common_params::*;

  // rx_valid qualifies rx_data for exactly one cycle per byte; there is no
  // backpressure, so every byte must be taken the cycle it is offered.
  // we_boot is a one-cycle strobe with wdata_data/wdata_addr valid alongside.
  logic              boot_req;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [BITS-1:0]   wdata_data;
  logic [ADDRW:0]    wdata_addr;
  logic              we_boot;
  logic              bootloading;
  logic              boot_done;
  logic              boot_err;

  modport slave (
    input  boot_req, rx_data, rx_valid,
    output wdata_data, wdata_addr, we_boot, bootloading, boot_done, boot_err
  );

  modport master (
    output boot_req, rx_data, rx_valid,
    input  wdata_data, wdata_addr, we_boot, bootloading, boot_done, boot_err
  );

endinterface

// File: rtl/boot_word_asm.sv
// Little-endian word assembler: four bytes shift in, first byte ends in [7:0].
// last_byte (BOOT_CHECKSUM_EN only) flags the byte that completes a word.
module boot_word_asm
  import common_params::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            byte_en,
  input  logic [7:0]      byte_in,
  output logic [BITS-1:0] word,
  output logic            word_valid
`ifdef BOOT_CHECKSUM_EN
  ,
  output logic            last_byte
`endif
);

  logic [1:0] byte_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word       <= '0;
      byte_cnt   <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        word     <= '0;
        byte_cnt <= '0;
      end else if (byte_en) begin
        word       <= {byte_in, word[BITS-1:8]};
        byte_cnt   <= byte_cnt + 2'd1;
        word_valid <= (byte_cnt == 2'd3);
      end
    end
  end

`ifdef BOOT_CHECKSUM_EN
  assign last_byte = byte_en && (byte_cnt == 2'd3);
`endif

endmodule

// File: rtl/boot_loader.sv
// UART boot loader: length header, little-endian words into I-MEM, optional
// trailing 8-bit sum checked when BOOT_CHECKSUM_EN is defined.
module boot_loader
  import common_params::*;
#(
  parameter int MAX_WORDS = 8192
) (
  input  logic          clk,
  input  logic          rst,
  boot_loader_if.slave  bus,
  output boot_state_t   state_dbg
);

  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  boot_state_t     state, state_nxt;
  logic            start;
  logic [7:0]      len_lo;
  logic [15:0]     n_words;
  logic [15:0]     len_rx;
  logic [ADDRW:0]  word_idx;
  logic            last_word;
  logic            asm_en;
  logic [BITS-1:0] asm_word;
  logic            asm_valid;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]      acc;
  logic            asm_last;
`endif

  assign len_rx    = {bus.rx_data, len_lo};
  assign last_word = (16'(word_idx) == n_words - 16'd1);
  assign asm_en    = bus.rx_valid && (state == DATA);

  boot_word_asm u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (start),
    .byte_en    (asm_en),
    .byte_in    (bus.rx_data),
    .word       (asm_word),
    .word_valid (asm_valid)
`ifdef BOOT_CHECKSUM_EN
    ,
    .last_byte  (asm_last)
`endif
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE, DONE, ERROR: begin
        if (bus.boot_req) begin
          state_nxt = LEN_LO;
          start     = 1'b1;
        end
      end
      LEN_LO: if (bus.rx_valid) state_nxt = LEN_HI;
      LEN_HI: begin
        if (bus.rx_valid) begin
          if ({1'b0, len_rx} > MAX_N) begin
            state_nxt = ERROR;
          end else if (len_rx == 16'd0) begin
`ifdef BOOT_CHECKSUM_EN
            state_nxt = CHK;
`else
            state_nxt = DONE;
`endif
          end else begin
            state_nxt = DATA;
          end
        end
      end
      DATA: begin
`ifdef BOOT_CHECKSUM_EN
        // Leave on the completing byte so a checksum byte landing in the
        // write-strobe cycle is already seen by CHK.
        if (asm_last && last_word) state_nxt = CHK;
`else
        if (asm_valid && last_word) state_nxt = DONE;
`endif
      end
`ifdef BOOT_CHECKSUM_EN
      CHK: begin
        if (bus.rx_valid) state_nxt = (bus.rx_data == acc) ? DONE : ERROR;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_lo   <= '0;
      n_words  <= '0;
      word_idx <= '0;
`ifdef BOOT_CHECKSUM_EN
      acc      <= '0;
`endif
    end else if (start) begin
      len_lo   <= '0;
      n_words  <= '0;
      word_idx <= '0;
`ifdef BOOT_CHECKSUM_EN
      acc      <= '0;
`endif
    end else begin
      if (state == LEN_LO && bus.rx_valid) len_lo <= bus.rx_data;
      if (state == LEN_HI && bus.rx_valid) n_words <= len_rx;
      if (asm_valid) word_idx <= word_idx + 1'b1;
`ifdef BOOT_CHECKSUM_EN
      if (asm_en) acc <= acc + bus.rx_data;
`endif
    end
  end

  always_comb begin
    bus.bootloading = 1'b0;
    case (state)
      LEN_LO, LEN_HI, DATA: bus.bootloading = 1'b1;
`ifdef BOOT_CHECKSUM_EN
      CHK:                  bus.bootloading = 1'b1;
`endif
      default:              bus.bootloading = 1'b0;
    endcase
  end

  assign bus.we_boot    = asm_valid;
  assign bus.wdata_data = asm_word;
  assign bus.wdata_addr = word_idx;
  assign bus.boot_done  = (state == DONE);
  assign bus.boot_err   = (state == ERROR);
  assign state_dbg      = state;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: directed byte streams, expected I-MEM writes queued
// and matched by a monitor; status levels checked after each load.
module tb_boot_loader;
  import common_params::*;

  localparam int W = ADDRW + 1 + BITS;

  logic        clk = 1'b0;
  logic        rst;
  boot_state_t state_dbg;

  boot_loader_if bus();

  boot_loader #(.MAX_WORDS(8192)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  int checks = 0;
  int errors = 0;

  always @(negedge clk) begin
    if (!rst && bus.we_boot) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected: got addr %0d data %h, required no write",
                 bus.wdata_addr, bus.wdata_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({bus.wdata_addr, bus.wdata_data} !== mon_exp) begin
          errors++;
          $display("FAIL write: got addr %0d data %h, required addr %0d data %h",
                   bus.wdata_addr, bus.wdata_data, mon_exp[W-1:BITS], mon_exp[BITS-1:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic pulse_boot();
    bus.boot_req = 1'b1;
    @(negedge clk);
    bus.boot_req = 1'b0;
  endtask

  task automatic push_exp(input logic [ADDRW:0] a, input logic [BITS-1:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic wait_end(input string name);
    int n;
    n = 0;
    while (!(bus.boot_done || bus.boot_err) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL %s_timeout: got no done/err in 50 cycles, required one", name);
    end
  endtask

  task automatic drain(input string name);
    repeat (3) @(negedge clk);
    check({name, "_pending_writes"}, exp_q.size(), 0);
  endtask

  task automatic check_status(input string name, input logic done, input logic err);
    check({name, "_done"}, bus.boot_done, done);
    check({name, "_err"}, bus.boot_err, err);
    check({name, "_bootloading"}, bus.bootloading, 1'b0);
  endtask

  // Two-word program; chk is the trailing checksum byte (ignored without checksum).
  task automatic run_basic(input string name, input logic [7:0] chk, input logic ok);
    push_exp(0, 32'h0000_0013);
    push_exp(1, 32'h0010_0093);
    pulse_boot();
    check({name, "_bootloading_hi"}, bus.bootloading, 1'b1);
    send_byte(8'h02);
    send_byte(8'h00);
    send_word(32'h0000_0013);
    send_word(32'h0010_0093);
    send_byte(chk);
    wait_end(name);
    drain(name);
    check_status(name, ok, !ok);
  endtask

  function automatic logic [31:0] word_pat(input int i);
    logic [7:0] lo;
    lo = i[7:0];
    return {lo ^ 8'h5A, i[15:8], ~lo, lo + 8'h11};
  endfunction

  initial begin
    logic [31:0] w;
    logic [7:0]  sum;

    rst          = 1'b1;
    bus.boot_req = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_state", state_dbg, IDLE);
    check("rst_we_boot", bus.we_boot, 1'b0);
    check("rst_addr", bus.wdata_addr, 0);
    check("rst_data", bus.wdata_data, 0);
    check("rst_bootloading", bus.bootloading, 1'b0);
    check("rst_done", bus.boot_done, 1'b0);
    check("rst_err", bus.boot_err, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // bytes in IDLE are ignored
    send_byte(8'h02);
    send_byte(8'h00);
    check("idle_ignore_state", state_dbg, IDLE);

    // two-word load, correct checksum
    run_basic("basic", 8'hB6, 1'b1);

    // bytes in DONE are ignored
    send_word(32'h5555_5555);
    drain("done_ignore");
    check("done_ignore_done", bus.boot_done, 1'b1);

`ifdef BOOT_CHECKSUM_EN
    // bad checksum, restarting from DONE
    run_basic("bad_chk", 8'hB7, 1'b0);
`endif

    // oversize length
    pulse_boot();
    send_byte(8'h01);
    send_byte(8'h20);
    wait_end("oversize");
    drain("oversize");
    check_status("oversize", 1'b0, 1'b1);

    // zero length
    pulse_boot();
    send_byte(8'h00);
    send_byte(8'h00);
`ifdef BOOT_CHECKSUM_EN
    send_byte(8'h00);
`endif
    wait_end("zero_len");
    drain("zero_len");
    check_status("zero_len", 1'b1, 1'b0);

    // reset after six payload bytes: only word 0 may be written
    push_exp(0, 32'h0000_0013);
    pulse_boot();
    send_byte(8'h02);
    send_byte(8'h00);
    send_word(32'h0000_0013);
    send_byte(8'h93);
    send_byte(8'h00);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_state", state_dbg, IDLE);
    check("midrst_we_boot", bus.we_boot, 1'b0);
    rst = 1'b0;
    drain("midrst");
    check_status("midrst", 1'b0, 1'b0);
    run_basic("after_rst", 8'hB6, 1'b1);

    // full-size back-to-back load
    pulse_boot();
    send_byte(8'h00);
    send_byte(8'h20);
    sum = 8'h00;
    for (int i = 0; i < 8192; i++) begin
      w = word_pat(i);
      push_exp(i[ADDRW:0], w);
      sum = sum + w[7:0] + w[15:8] + w[23:16] + w[31:24];
      send_word(w);
    end
    send_byte(sum);
    wait_end("full");
    drain("full");
    check_status("full", 1'b1, 1'b0);
    check("full_final_addr", bus.wdata_addr, 8192);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
